// File: rtl/nor_gate_checker_pkg.sv
// nor_gate_checker_pkg
// Shared definitions for the NOR gate-derivation checker: FSM state
// encoding, the width of the observed output bus, the bit position of each
// derived gate within that bus, and the golden expected-value function.
package nor_gate_checker_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_CHECK  = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam int OBS_W = 6;

  // Bit positions inside obs / expected / err_mask
  localparam int IDX_A_NOT  = 5;
  localparam int IDX_B_NOT  = 4;
  localparam int IDX_AB_OR  = 3;
  localparam int IDX_AB_AND = 2;
  localparam int IDX_AB_NOR = 1;
  localparam int IDX_AB_NAND = 0;

  // Expected response of a correct gate-derivation block for inputs {a,b}
  function automatic logic [OBS_W-1:0] expected_obs(input logic a, input logic b);
    logic [OBS_W-1:0] e;
    e              = {OBS_W{1'b0}};
    e[IDX_A_NOT]   = ~a;
    e[IDX_B_NOT]   = ~b;
    e[IDX_AB_OR]   = a | b;
    e[IDX_AB_AND]  = a & b;
    e[IDX_AB_NOR]  = ~(a | b);
    e[IDX_AB_NAND] = ~(a & b);
    return e;
  endfunction

endpackage

// File: rtl/nor_gate_checker_if.sv
// nor_gate_checker_if
// Bundles the checker's control, stimulus, response and result signals.
//   start      : request a full four-vector sweep
//   a, b       : stimulus driven to the block under check
//   obs        : six derived-gate outputs returned by the block under check
//   busy, done : sweep in progress / sweep finished
//   pass, err_count, err_mask, first_fail : sweep results
// master = checker side, slave = environment (block under check + controller).
interface nor_gate_checker_if;
  import nor_gate_checker_pkg::*;

  logic             start;
  logic             a;
  logic             b;
  logic [OBS_W-1:0] obs;
  logic             busy;
  logic             done;
  logic             pass;
  logic [2:0]       err_count;
  logic [OBS_W-1:0] err_mask;
  logic [1:0]       first_fail;

  modport master (
    input  start, obs,
    output a, b, busy, done, pass, err_count, err_mask, first_fail
  );

  modport slave (
    output start, obs,
    input  a, b, busy, done, pass, err_count, err_mask, first_fail
  );

endinterface

// File: rtl/nor_gate_checker_expected_gen.sv
// nor_expected_gen
// Purely combinational golden model of the universal-NOR derivation block.
//   a, b     : gate inputs
//   expected : {a_not, b_not, ab_or, ab_and, ab_nor, ab_nand}
module nor_expected_gen
  import nor_gate_checker_pkg::*;
(
  input  logic             a,
  input  logic             b,
  output logic [OBS_W-1:0] expected
);

  assign expected = expected_obs(a, b);

endmodule

// File: rtl/nor_gate_checker.sv
// nor_gate_checker
// Clocked stimulus/response checker for a NOR gate-derivation block. On
// start it walks {a,b} through 00,01,10,11, holds each vector for
// SETTLE_CYCLES cycles, then compares obs against the golden model for one
// cycle. Results are accumulated and held once the sweep completes.
//   clk : rising-edge clock
//   rst : synchronous active-high reset (aborts any sweep)
//   bus : nor_gate_checker_if master modport (start/obs in; a/b and results out)
module nor_gate_checker
  import nor_gate_checker_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2   // legal range 1..15
) (
  input logic                clk,
  input logic                rst,
  nor_gate_checker_if.master bus
);

  localparam logic [3:0] CNT_RELOAD = 4'(SETTLE_CYCLES - 1);

  state_t           state_r;
  logic [1:0]       vec_r;
  logic [3:0]       cnt_r;
  logic             a_r;
  logic             b_r;
  logic             busy_r;
  logic             done_r;
  logic             pass_r;
  logic [2:0]       err_count_r;
  logic [OBS_W-1:0] err_mask_r;
  logic [1:0]       first_fail_r;

  logic [OBS_W-1:0] expected_s;
  logic [OBS_W-1:0] diff_s;
  logic             fail_s;
  logic [2:0]       err_next_s;
  logic [1:0]       vec_next_s;

  nor_expected_gen u_expected (
    .a        (a_r),
    .b        (b_r),
    .expected (expected_s)
  );

  // Per-vector comparison and next-value helpers used by the CHECK state
  always_comb begin
    diff_s     = bus.obs ^ expected_s;
    fail_s     = |diff_s;
    err_next_s = err_count_r + {2'b00, fail_s};
    vec_next_s = vec_r + 2'd1;
  end

  // Sweep FSM with registered stimulus and result outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      vec_r        <= 2'd0;
      cnt_r        <= 4'd0;
      a_r          <= 1'b0;
      b_r          <= 1'b0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      pass_r       <= 1'b0;
      err_count_r  <= 3'd0;
      err_mask_r   <= {OBS_W{1'b0}};
      first_fail_r <= 2'd0;
    end else begin
      case (state_r)
        // A restart from DONE clears the previous results on the same edge
        ST_IDLE, ST_DONE: begin
          if (bus.start) begin
            state_r      <= ST_SETTLE;
            vec_r        <= 2'd0;
            cnt_r        <= CNT_RELOAD;
            a_r          <= 1'b0;
            b_r          <= 1'b0;
            busy_r       <= 1'b1;
            done_r       <= 1'b0;
            pass_r       <= 1'b0;
            err_count_r  <= 3'd0;
            err_mask_r   <= {OBS_W{1'b0}};
            first_fail_r <= 2'd0;
          end
        end
        ST_SETTLE: begin
          if (cnt_r == 4'd0) begin
            state_r <= ST_CHECK;
          end else begin
            cnt_r <= cnt_r - 4'd1;
          end
        end
        ST_CHECK: begin
          err_count_r <= err_next_s;
          err_mask_r  <= err_mask_r | diff_s;
          // No earlier failure means this is the first failing vector
          if (fail_s && (err_count_r == 3'd0)) begin
            first_fail_r <= vec_r;
          end
          // Exit is decided on vec==3 before incrementing, so vec never wraps
          if (vec_r == 2'd3) begin
            state_r <= ST_DONE;
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
            pass_r  <= (err_next_s == 3'd0);
          end else begin
            state_r    <= ST_SETTLE;
            vec_r      <= vec_next_s;
            {a_r, b_r} <= vec_next_s;
            cnt_r      <= CNT_RELOAD;
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.a          = a_r;
  assign bus.b          = b_r;
  assign bus.busy       = busy_r;
  assign bus.done       = done_r;
  assign bus.pass       = pass_r;
  assign bus.err_count  = err_count_r;
  assign bus.err_mask   = err_mask_r;
  assign bus.first_fail = first_fail_r;

endmodule

// File: doc/nor_gate_checker.md
Name: nor_gate_checker

Overview:
- Self-checking stimulus/response stage that drives a universal-NOR gate-derivation block.
- Walks the two gate inputs through all four combinations, waits a settle interval, captures the six derived-gate outputs and compares them against internally computed expected values.
- Reports pass/fail, a per-output mismatch mask and the first failing vector.
- Replaces hand-written delay-driven stimulus with a clocked, synthesizable checker usable on the lab board.

Parameters:
- SETTLE_CYCLES, 2, clock cycles between applying a vector and sampling the outputs; legal range 1..15.

Ports:
- clk  input  1  system clock, all state on rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  single-cycle request to run a full sweep
- a  output  1  gate input A driven to the block under check
- b  output  1  gate input B driven to the block under check
- obs  input  6  observed outputs: [5]=a_not [4]=b_not [3]=ab_or [2]=ab_and [1]=ab_nor [0]=ab_nand
- busy  output  1  high in SETTLE and CHECK
- done  output  1  high while in DONE
- pass  output  1  valid when done; 1 iff err_count==0
- err_count  output  3  number of vectors with at least one mismatching bit, 0..4
- err_mask  output  6  OR over all vectors of (obs XOR expected), same bit order as obs
- first_fail  output  2  {a,b} of the first failing vector; 0 if none

Behaviour:
- Reset (synchronous, rst high at a rising edge): state=IDLE, a=0, b=0, busy=0, done=0, pass=0, err_count=0, err_mask=0, first_fail=0, vector index=0, settle counter=0. Reset overrides start and aborts any sweep mid-operation, with no partial results retained.
- FSM states: IDLE, SETTLE, CHECK, DONE.
- IDLE:
  - start=1 -> clear err_count, err_mask and first_fail; set vec=0, {a,b}=00; load counter with SETTLE_CYCLES-1; go to SETTLE.
- SETTLE:
  - counter==0 -> CHECK; otherwise decrement the counter.
  - {a,b} held stable.
- CHECK (exactly one cycle): sample obs and compute expected from the current {a,b}: {~a, ~b, a|b, a&b, ~(a|b), ~(a&b)}.
  - diff = obs ^ expected.
  - If diff!=0: err_count += 1; err_mask |= diff; if this is the first failing vector, first_fail = vec.
  - If vec==3 -> DONE. Otherwise vec += 1, {a,b} = vec+1 (a is the MSB), reload the counter, go to SETTLE.
- DONE:
  - done=1, pass=(err_count==0), {a,b} held at 11, results held.
  - start=1 -> restart exactly as from IDLE, clearing the results in the same edge.
- start while busy is ignored.
- Latency: DONE is entered 4*(SETTLE_CYCLES+1) rising edges after the edge that samples start. With the default of 2, that is 12 edges.
- Width rules:
  - err_count saturates naturally at 4, so 3 bits is sufficient.
  - vec is 2 bits; it must not wrap, because exit to DONE is decided on vec==3 before any increment.
- obs is treated as combinational from {a,b}. Compliance requires SETTLE_CYCLES to cover the path delay; the checker does not synchronize obs.

Decomposition:
- Shared package holds:
  - state encoding typedef (IDLE=0, SETTLE=1, CHECK=2, DONE=3);
  - OBS_W=6;
  - the bit-index constants for obs;
  - a function returning the expected 6-bit vector for a given {a,b}. The testbench reuses this function as its reference model.
- One natural sub-module: nor_expected_gen, a purely combinational 2-in/6-out golden model.
- FSM, counters and result registers stay in nor_gate_checker.

Test Plan:
- Correct NOR-derived block on obs, SETTLE_CYCLES=2, start pulse -> done high at edge 12, pass=1, err_count=0, err_mask=000000, first_fail=00.
- ab_nor and ab_nand wired swapped at the checker input -> err_count=2 (vectors 01 and 10), err_mask=000011, first_fail=01, pass=0.
- ab_and stuck at 0 -> err_count=1, err_mask=000100, first_fail=11, pass=0.
- rst asserted while in SETTLE for vector 10 -> next cycle: state IDLE, a=b=0, err_count=0, done=0; a fresh start gives the full 12-edge sweep.
- start pulsed again during busy -> ignored, done still at edge 12; start in DONE -> results cleared on that edge, busy=1, {a,b}=00, second sweep reproduces the first.
- SETTLE_CYCLES=1 with a correct block -> done at edge 8, pass=1; check {a,b} sequence 00,01,10,11 each held 2 cycles.
